// File: rtl/nx_xrfb_fifo_ctrl.sv
// rtl/nx_xrfb_fifo_ctrl.sv - show-ahead FIFO controller sequencing an external NX_XRFB register file
// Pointers, occupancy and flags live here; storage is the RF, read combinationally through RF_RA->RF_O.
module nx_xrfb_fifo_ctrl #(
   parameter int DEPTH_LOG2 = 6,
   parameter int WIDTH      = 18,
   parameter int AFULL_LVL  = 56,
   parameter int AEMPTY_LVL = 8
) (
   input  logic                  CK,
   input  logic                  R,
   input  logic                  FLUSH,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [WIDTH-1:0]      IN_DATA,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [WIDTH-1:0]      OUT_DATA,
   output logic [WIDTH-1:0]      RF_I,
   output logic [DEPTH_LOG2-1:0] RF_WA,
   output logic [DEPTH_LOG2-1:0] RF_RA,
   output logic                  RF_WE,
   output logic                  RF_WEA,
   input  logic [WIDTH-1:0]      RF_O,
   output logic [DEPTH_LOG2:0]   COUNT,
   output logic                  AFULL,
   output logic                  AEMPTY,
   output logic [DEPTH_LOG2:0]   HWM
);

   localparam int CW = DEPTH_LOG2 + 1;
   localparam logic [DEPTH_LOG2:0] DEPTH_C  = CW'(1 << DEPTH_LOG2);
   localparam logic [DEPTH_LOG2:0] AFULL_C  = CW'(AFULL_LVL);
   localparam logic [DEPTH_LOG2:0] AEMPTY_C = CW'(AEMPTY_LVL);

   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic [DEPTH_LOG2:0]   count, hwm, next_count;
   logic                  full, empty, push, pop;

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   // Ready depends only on state, so a full FIFO refuses a push even when a pop frees a slot.
   assign IN_READY  = !full && !R && !FLUSH;
   assign OUT_VALID = !empty && !R && !FLUSH;
   assign push      = IN_VALID && IN_READY;
   assign pop       = OUT_VALID && OUT_READY;

   assign RF_I     = IN_DATA;
   assign RF_WA    = wptr;
   assign RF_RA    = rptr;
   assign RF_WE    = push;
   assign RF_WEA   = 1'b1;
   assign OUT_DATA = RF_O;

   assign COUNT  = count;
   assign HWM    = hwm;
   assign AFULL  = (count >= AFULL_C);
   assign AEMPTY = (count <= AEMPTY_C);

   always_comb begin
      next_count = count;
      if (push && !pop)
         next_count = count + 1'b1;
      else if (pop && !push)
         next_count = count - 1'b1;
   end

   always_ff @(posedge CK) begin
      if (R || FLUSH) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         hwm   <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         count <= next_count;
         if (next_count > hwm)
            hwm <= next_count;
      end
   end

endmodule

// File: tb/tb_nx_xrfb_fifo_ctrl.sv
// tb/tb_nx_xrfb_fifo_ctrl.sv - scoreboard bench for nx_xrfb_fifo_ctrl with a behavioural RF model
module tb_nx_xrfb_fifo_ctrl;

   localparam int DL = 6;
   localparam int W  = 18;
   localparam int D  = 64;

   logic          CK = 1'b0;
   logic          R = 1'b1, FLUSH = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0;
   logic [W-1:0]  IN_DATA = '0;
   logic          IN_READY, OUT_VALID, RF_WE, RF_WEA, AFULL, AEMPTY;
   logic [W-1:0]  OUT_DATA, RF_I, RF_O;
   logic [DL-1:0] RF_WA, RF_RA;
   logic [DL:0]   COUNT, HWM;

   int checks = 0;
   int errors = 0;

   always #5 CK = ~CK;

   nx_xrfb_fifo_ctrl #(.DEPTH_LOG2(DL), .WIDTH(W), .AFULL_LVL(56), .AEMPTY_LVL(8)) dut (
      .CK(CK), .R(R), .FLUSH(FLUSH),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
      .RF_I(RF_I), .RF_WA(RF_WA), .RF_RA(RF_RA), .RF_WE(RF_WE), .RF_WEA(RF_WEA),
      .RF_O(RF_O), .COUNT(COUNT), .AFULL(AFULL), .AEMPTY(AEMPTY), .HWM(HWM)
   );

   // Register-file primitive stand-in: edge write, combinational read.
   logic [W-1:0] mem [0:D-1];
   initial for (int i = 0; i < D; i++) mem[i] = '0;
   always @(posedge CK) if (RF_WE && RF_WEA) mem[RF_WA] <= RF_I;
   assign RF_O = mem[RF_RA];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of words in flight, write/read totals, peak occupancy.
   logic [W-1:0] q[$];
   int wtot = 0, rtot = 0, mhwm = 0;

   always @(negedge CK) begin
      logic e_in_ready, e_out_valid, e_push, e_pop;
      e_in_ready  = (q.size() < D) && !R && !FLUSH;
      e_out_valid = (q.size() > 0) && !R && !FLUSH;
      e_push      = IN_VALID && e_in_ready;
      e_pop       = OUT_READY && e_out_valid;
      chk("in_ready", IN_READY, e_in_ready);
      chk("out_valid", OUT_VALID, e_out_valid);
      chk("count", COUNT, q.size());
      chk("afull", AFULL, q.size() >= 56);
      chk("aempty", AEMPTY, q.size() <= 8);
      chk("hwm", HWM, mhwm);
      chk("rf_we", RF_WE, e_push);
      chk("rf_wea", RF_WEA, 1'b1);
      chk("rf_wa", RF_WA, wtot % D);
      chk("rf_ra", RF_RA, rtot % D);
      chk("rf_i", RF_I, IN_DATA);
      if (e_out_valid) chk("out_data", OUT_DATA, q[0]);
      if (R || FLUSH) begin
         q.delete();
         wtot = 0; rtot = 0; mhwm = 0;
      end else begin
         if (e_pop) begin
            void'(q.pop_front());
            rtot++;
         end
         if (e_push) begin
            q.push_back(IN_DATA);
            wtot++;
         end
         if (q.size() > mhwm) mhwm = q.size();
      end
   end

   task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy,
                      input logic fl = 1'b0, input logic rr = 1'b0);
      IN_VALID = iv; IN_DATA = d; OUT_READY = ordy; FLUSH = fl; R = rr;
      @(posedge CK);
      #1;
   endtask

   initial begin
      int pv, pr;
      cyc(1'b1, 18'h3ffff, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 18'h3ffff, 1'b1, 1'b0, 1'b1);

      for (int i = 1; i <= 3; i++) cyc(1'b1, W'(i), 1'b0);
      @(negedge CK);
      chk("dir_count3", COUNT, 3);
      chk("dir_head1", OUT_DATA, 1);
      chk("dir_hwm3", HWM, 3);

      for (int i = 3; i < D; i++) cyc(1'b1, W'(i), 1'b0);
      @(negedge CK);
      chk("dir_full_ready", IN_READY, 0);
      chk("dir_full_count", COUNT, 64);
      cyc(1'b1, 18'h99, 1'b0);
      cyc(1'b1, 18'h100, 1'b1);
      @(negedge CK);
      chk("dir_full_pop", COUNT, 63);
      cyc(1'b1, 18'h101, 1'b1);
      @(negedge CK);
      chk("dir_both", COUNT, 63);

      repeat (70) cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 200; i++) cyc(1'b1, W'(i + 'h200), 1'b1);
      @(negedge CK);
      chk("dir_stream_count", COUNT, 1);
      chk("dir_stream_hwm", HWM, 1);
      cyc(1'b0, '0, 1'b1);

      cyc(1'b1, 18'h3ab, 1'b1);
      @(negedge CK);
      chk("dir_ft_valid", OUT_VALID, 1);
      chk("dir_ft_data", OUT_DATA, 18'h3ab);
      cyc(1'b0, '0, 1'b1);

      for (int i = 0; i < 10; i++) cyc(1'b1, W'(i + 'h40), 1'b0);
      cyc(1'b1, 18'h155, 1'b0, 1'b1);
      @(negedge CK);
      chk("dir_flush_count", COUNT, 0);
      chk("dir_flush_hwm", HWM, 0);
      for (int i = 0; i < 10; i++) cyc(1'b1, W'(i + 'h80), 1'b1);
      cyc(1'b1, 18'h2aa, 1'b1, 1'b0, 1'b1);
      @(negedge CK);
      chk("dir_rst_count", COUNT, 0);
      chk("dir_rst_valid", OUT_VALID, 0);

      for (int ph = 0; ph < 4; ph++) begin
         pv = (ph == 0) ? 90 : (ph == 1) ? 20 : 60;
         pr = (ph == 0) ? 20 : (ph == 1) ? 90 : 55;
         repeat (800)
            cyc($urandom_range(0, 99) < pv, W'($urandom), $urandom_range(0, 99) < pr,
                $urandom_range(0, 299) == 0, $urandom_range(0, 599) == 0);
      end
      repeat (3) cyc(1'b0, '0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
